// File: rtl/sccb_target_if.sv
// Host-side register port of the SCCB target: write notifications and a local read port.
// The open-drain SCCB pins stay plain ports on the target.
interface sccb_target_if;
    logic       wr_tick;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave  (output wr_tick, wr_addr, wr_data, rd_data, busy, input  rd_addr);
    modport master (input  wr_tick, wr_addr, wr_data, rd_data, busy, output rd_addr);
endinterface

// File: rtl/sccb_target.sv
// SCCB target: decodes 3-phase writes and 2-phase reads into a 256x8 register file,
// answering on an open-drain data line like an OV7670 camera.
module sccb_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] REG_RESET   = 8'h00,
    parameter logic [7:0] SRST_REG    = 8'h12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmos_scl,
    inout  wire          cmos_sda,
    sccb_target_if.slave host
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic [7:0]             shift_q, shift_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [7:0]             ptr_q, ptr_d;
    logic [7:0]             tx_q, tx_d;
    logic                   rw_q, rw_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   wr_tick_q, wr_tick_d;
    logic [7:0]             wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic                   srst_pend_q, srst_pend_d;
    logic [7:0]             regs_q [256];
    logic [7:0]             regs_d [256];

    logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   =  scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s &  scl_prev_q;
    assign start_cond =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_cond  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

    assign cmos_sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign host.wr_tick  = wr_tick_q;
    assign host.wr_addr  = wr_addr_q;
    assign host.wr_data  = wr_data_q;
    assign host.rd_data  = rd_data_q;
    assign host.busy     = (state_q != IDLE);

    always_comb begin
        scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], cmos_scl};
        sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], cmos_sda};
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        wr_tick_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        srst_pend_d = 1'b0;
        rd_data_d   = regs_q[host.rd_addr];
        regs_d      = regs_q;

        if (srst_pend_q) begin
            for (int i = 0; i < 256; i++) regs_d[i] = REG_RESET;
        end

        if (start_cond) begin
            state_d  = DEV;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else if (stop_cond) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            if (scl_rise && cnt_q < 4'd8 &&
                (state_q == DEV || state_q == SUB || state_q == WDATA)) begin
                shift_d = {shift_q[6:0], sda_s};
                cnt_d   = cnt_q + 4'd1;
            end

            // The master's ACK/NA after a read byte decides whether the next byte follows.
            if (scl_rise && state_q == RD_NA) begin
                if (sda_s) begin
                    state_d = IGNORE;
                end else begin
                    ptr_d   = ptr_q + 8'd1;
                    tx_d    = regs_q[ptr_q + 8'd1];
                    cnt_d   = 4'd0;
                    state_d = RDATA;
                end
            end

            if (scl_fall) begin
                case (state_q)
                    DEV: if (cnt_q == 4'd8) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                            state_d  = DEV_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IGNORE;
                        end
                    end
                    DEV_ACK: begin
                        cnt_d = 4'd0;
                        if (!rw_q) begin
                            sda_oe_d = 1'b0;
                            state_d  = SUB;
                        end else begin
                            sda_oe_d = ~regs_q[ptr_q][7];
                            tx_d     = {regs_q[ptr_q][6:0], 1'b0};
                            cnt_d    = 4'd1;
                            state_d  = RDATA;
                        end
                    end
                    SUB: if (cnt_q == 4'd8) begin
                        ptr_d    = shift_q;
                        sda_oe_d = 1'b1;
                        state_d  = SUB_ACK;
                    end
                    SUB_ACK: begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = WDATA;
                    end
                    WDATA: if (cnt_q == 4'd8) begin
                        sda_oe_d      = 1'b1;
                        regs_d[ptr_q] = shift_q;
                        wr_tick_d     = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = shift_q;
                        srst_pend_d   = (ptr_q == SRST_REG) && shift_q[7];
                        state_d       = WDATA_ACK;
                    end
                    WDATA_ACK: begin
                        sda_oe_d = 1'b0;
                        ptr_d    = ptr_q + 8'd1;
                        cnt_d    = 4'd0;
                        state_d  = WDATA;
                    end
                    RDATA: begin
                        if (cnt_q < 4'd8) begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_NA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            shift_q     <= 8'h00;
            cnt_q       <= 4'd0;
            ptr_q       <= 8'h00;
            tx_q        <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_tick_q   <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            rd_data_q   <= 8'h00;
            srst_pend_q <= 1'b0;
            for (int i = 0; i < 256; i++) regs_q[i] <= REG_RESET;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            wr_tick_q   <= wr_tick_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= rd_data_d;
            srst_pend_q <= srst_pend_d;
            regs_q      <= regs_d;
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: a bit-banged SCCB master drives transfers while a scoreboard
// matches every wr_tick against the writes the stimulus announced.
module tb_sccb_target;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  cmos_sda;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    sccb_target_if host();

    pullup (cmos_sda);
    assign cmos_sda = m_sda_low ? 1'b0 : 1'bz;

    sccb_target dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmos_scl (scl),
        .cmos_sda (cmos_sda),
        .host     (host)
    );

    always #5 clk = ~clk;

    task automatic wait_q();
        repeat (10) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b0; wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            m_sda_low = ~b[7-i]; wait_q();
            scl = 1'b1; wait_q(); wait_q();
            scl = 1'b0; wait_q();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        ack = (cmos_sda === 1'b0);
        wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d, output logic sda9);
        for (int i = 0; i < 8; i++) begin
            m_sda_low = 1'b0; wait_q();
            scl = 1'b1; wait_q();
            d[7-i] = cmos_sda;
            wait_q();
            scl = 1'b0; wait_q();
        end
        m_sda_low = ~nack; wait_q();
        scl = 1'b1; wait_q();
        sda9 = cmos_sda;
        wait_q();
        scl = 1'b0; wait_q();
        m_sda_low = 1'b0;
    endtask

    // Full transfer of the first n bytes of 'bytes' (MSB byte first), bracketed by START/STOP.
    task automatic send_txn(input logic [31:0] bytes, input int n, output logic [3:0] acks);
        logic a;
        acks = 4'b0000;
        bus_start();
        for (int i = 0; i < n; i++) begin
            write_byte(bytes[31-8*i -: 8], a);
            acks[i] = a;
        end
        bus_stop();
    endtask

    task automatic wr_monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (host.wr_tick === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_tick_unexpected: got addr=%02h data=%02h, no write expected",
                             host.wr_addr, host.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({host.wr_addr, host.wr_data} !== e) begin
                        errors++;
                        $display("FAIL wr_tick_payload: got %02h/%02h, expected %02h/%02h",
                                 host.wr_addr, host.wr_data, e[15:8], e[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0; host.rd_addr = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", host.busy); end
        checks++; if (host.wr_tick !== 1'b0) begin errors++; $display("FAIL reset_wr_tick: got %b expected 0", host.wr_tick); end
        checks++; if ({host.wr_addr, host.wr_data} !== 16'h0000) begin errors++; $display("FAIL reset_wr_regs: got %02h/%02h expected 00/00", host.wr_addr, host.wr_data); end
        checks++; if (host.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %02h expected 00", host.rd_data); end
        checks++; if (cmos_sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected released (1)", cmos_sda); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_write();
        logic [3:0] acks;
        logic busy_mid;
        exp_q.push_back(16'h1204);
        bus_start();
        for (int i = 0; i < 3; i++) begin
            write_byte(i == 0 ? 8'h42 : (i == 1 ? 8'h12 : 8'h04), acks[i]);
        end
        busy_mid = host.busy;
        bus_stop();
        checks++; if (acks[2:0] !== 3'b111) begin errors++; $display("FAIL basic_acks: got %b expected 111", acks[2:0]); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy_mid); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_stop: got %b expected 0", host.busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing_tick: got %0d pending, expected 0", exp_q.size()); end
        checks++; if ({host.wr_addr, host.wr_data} !== 16'h1204) begin errors++; $display("FAIL basic_wr_held: got %02h/%02h expected 12/04", host.wr_addr, host.wr_data); end
        host.rd_addr = 8'h12; @(negedge clk);
        checks++; if (host.rd_data !== 8'h04) begin errors++; $display("FAIL basic_rd12: got %02h expected 04", host.rd_data); end
    endtask

    task automatic test_soft_reset();
        logic [3:0] acks;
        exp_q.push_back(16'h8C03);
        send_txn(32'h428C0300, 3, acks);
        checks++; if (acks[2:0] !== 3'b111) begin errors++; $display("FAIL srst_acks1: got %b expected 111", acks[2:0]); end
        host.rd_addr = 8'h8C; @(negedge clk);
        checks++; if (host.rd_data !== 8'h03) begin errors++; $display("FAIL srst_rd8c_before: got %02h expected 03", host.rd_data); end
        exp_q.push_back(16'h1280);
        send_txn(32'h42128000, 3, acks);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL srst_missing_tick: got %0d pending, expected 0", exp_q.size()); end
        host.rd_addr = 8'h8C; @(negedge clk);
        checks++; if (host.rd_data !== 8'h00) begin errors++; $display("FAIL srst_rd8c_after: got %02h expected 00", host.rd_data); end
        host.rd_addr = 8'h12; @(negedge clk);
        checks++; if (host.rd_data !== 8'h00) begin errors++; $display("FAIL srst_rd12_after: got %02h expected 00", host.rd_data); end
    endtask

    task automatic test_wrong_addr();
        logic [3:0] acks;
        logic busy_mid;
        acks = 4'b0000;
        bus_start();
        for (int i = 0; i < 3; i++) begin
            write_byte(i == 0 ? 8'h44 : (i == 1 ? 8'h12 : 8'h04), acks[i]);
        end
        busy_mid = host.busy;
        bus_stop();
        checks++; if (acks[2:0] !== 3'b000) begin errors++; $display("FAIL wrong_addr_acks: got %b expected 000", acks[2:0]); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL wrong_addr_busy_mid: got %b expected 1", busy_mid); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy_after: got %b expected 0", host.busy); end
        host.rd_addr = 8'h12; @(negedge clk);
        checks++; if (host.rd_data !== 8'h00) begin errors++; $display("FAIL wrong_addr_rd12: got %02h expected 00", host.rd_data); end
    endtask

    task automatic test_read();
        logic [3:0] acks;
        logic a, sda9;
        logic [7:0] d0, d1;
        exp_q.push_back(16'h8C03);
        exp_q.push_back(16'h8DA5);
        send_txn(32'h428C03A5, 4, acks);
        checks++; if (acks !== 4'b1111) begin errors++; $display("FAIL read_setup_acks: got %b expected 1111", acks); end
        send_txn(32'h428C0000, 2, acks);
        checks++; if (acks[1:0] !== 2'b11) begin errors++; $display("FAIL read_ptr_acks: got %b expected 11", acks[1:0]); end
        bus_start();
        write_byte(8'h43, a);
        read_byte(1'b0, d0, sda9);
        read_byte(1'b1, d1, sda9);
        bus_stop();
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL read_dev_ack: got %b expected 1", a); end
        checks++; if (d0 !== 8'h03) begin errors++; $display("FAIL read_byte0: got %02h expected 03", d0); end
        checks++; if (d1 !== 8'hA5) begin errors++; $display("FAIL read_byte1: got %02h expected a5", d1); end
        checks++; if (sda9 !== 1'b1) begin errors++; $display("FAIL read_na_released: got %b expected 1", sda9); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL read_busy_after: got %b expected 0", host.busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL read_missing_tick: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        logic a0, a1;
        // Reset while the target is pulling the device-address ACK low.
        bus_start();
        send_bits(8'h42, 8);
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        checks++; if (cmos_sda !== 1'b0) begin errors++; $display("FAIL arst_ack_driven: got %b expected 0", cmos_sda); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cmos_sda !== 1'b1) begin errors++; $display("FAIL arst_sda_release: got %b expected 1", cmos_sda); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", host.busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        scl = 1'b0; wait_q();
        // Reset during bit 4 of a data byte to 8C (which holds 03 from earlier).
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h8C, a1);
        send_bits(8'hF0, 3);
        m_sda_low = 1'b1; wait_q();
        scl = 1'b1; repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cmos_sda !== 1'b0) begin errors++; $display("FAIL arst_master_bit: got %b expected 0", cmos_sda); end
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL arst_pre_acks: got %b expected 11", {a0, a1}); end
        m_sda_low = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (cmos_sda !== 1'b1) begin errors++; $display("FAIL arst_sda_idle: got %b expected 1", cmos_sda); end
        rst_n = 1'b1;
        scl = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        host.rd_addr = 8'h8C; @(negedge clk);
        checks++; if (host.rd_data !== 8'h00) begin errors++; $display("FAIL arst_rd8c: got %02h expected 00", host.rd_data); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL arst_busy_after: got %b expected 0", host.busy); end
        scl = 1'b0; wait_q();
        test_basic_write();
    endtask

    task automatic test_restart_wrap();
        logic [3:0] acks;
        logic a0, a1, a2, a3;
        exp_q.push_back(16'h2055);
        bus_start();
        write_byte(8'h42, a0);
        send_bits(8'h30, 4);
        bus_start();
        write_byte(8'h42, a1);
        write_byte(8'h20, a2);
        write_byte(8'h55, a3);
        bus_stop();
        checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL restart_acks: got %b expected 1111", {a0, a1, a2, a3}); end
        host.rd_addr = 8'h20; @(negedge clk);
        checks++; if (host.rd_data !== 8'h55) begin errors++; $display("FAIL restart_rd20: got %02h expected 55", host.rd_data); end
        exp_q.push_back(16'hFFAA);
        exp_q.push_back(16'h00BB);
        send_txn(32'h42FFAABB, 4, acks);
        checks++; if (acks !== 4'b1111) begin errors++; $display("FAIL wrap_acks: got %b expected 1111", acks); end
        host.rd_addr = 8'hFF; @(negedge clk);
        checks++; if (host.rd_data !== 8'hAA) begin errors++; $display("FAIL wrap_rdff: got %02h expected aa", host.rd_data); end
        host.rd_addr = 8'h00; @(negedge clk);
        checks++; if (host.rd_data !== 8'hBB) begin errors++; $display("FAIL wrap_rd00: got %02h expected bb", host.rd_data); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_missing_tick: got %0d pending, expected 0", exp_q.size()); end
    endtask

    initial begin
        fork
            wr_monitor();
        join_none
        test_reset();
        scl = 1'b1; wait_q();
        scl = 1'b0;
        test_basic_write();
        test_soft_reset();
        test_wrong_addr();
        test_read();
        test_async_reset();
        test_restart_wrap();
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
